em4100_decoder: RTL and testbench
=================================

Name: em4100_decoder

Overview:
- Downstream neighbour of the envelope slicer, which emits one amplitude-sliced level per carrier-derived period trigger.
- Samples that level once per period, pairs the half-bit symbols as Manchester, and frames the result as an EM4100 tag response: 9-one header, 10 rows of 4 data bits plus even parity, 4 column parity bits, and a stop bit.
- Outputs a parity-checked 40-bit tag ID with a one-cycle valid pulse, or a one-cycle error pulse.

Parameters:
- MANCHESTER, 1: 1 = two symbols per data bit (Manchester); 0 = one symbol per bit (raw NRZ).
- HEADER_LEN, 9: consecutive ones required to lock a frame.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- bit_in  input  1  sliced level from the upstream slicer
- period_trigger_in  input  1  same period trigger that drives the upstream slicer
- id_out  output  40  last good tag ID; first received data bit is id_out[39]
- id_valid_out  output  1  one-cycle pulse when id_out is updated
- parity_err_out  output  1  one-cycle pulse on a framed but failed frame
- locked_out  output  1  high while in DATA or CHECK

Behaviour:
- Reset:
  - Single clock clk_in; rst_in is asynchronous and active-low.
  - While rst_in = 0: all state clears; id_out=0, id_valid_out=0, parity_err_out=0, locked_out=0.
  - FSM goes to HUNT, Manchester phase is cleared, trig_prev=0.
  - Reset asserted mid-frame discards the partial frame. No pulse is emitted.
- Symbol strobe:
  - trig_prev registers period_trigger_in.
  - sym_stb fires in the cycle after a 0->1 edge of period_trigger_in. This lines up with the slicer's registered update.
  - bit_in is sampled only on sym_stb.
- Manchester pairing (MANCHESTER=1):
  - The first symbol is held and the second completes the pair.
  - Pair 1,0 -> data 1. Pair 0,1 -> data 0.
  - Pair 0,0 or 1,1 is a code violation: drop the first symbol, keep the second as the new first half (one-symbol slip), and force the FSM to HUNT.
  - A data-bit event (bit_stb) fires on the cycle the second symbol is sampled.
- NRZ mode (MANCHESTER=0): bit_stb equals sym_stb and the data bit equals the sampled symbol; no violations exist.
- HUNT state:
  - ones_cnt counts consecutive 1 data bits (4-bit, saturating at 15).
  - A 0 clears ones_cnt.
  - When ones_cnt reaches HEADER_LEN, go to DATA with bit_idx=0 and the shift register cleared.
- DATA state:
  - Each bit_stb shifts one bit into a 55-bit register and increments bit_idx.
  - On bit 55 (bit_idx 54) go to CHECK.
  - A violation returns to HUNT silently: no pulse, ones_cnt=0.
- CHECK state (exactly one cycle):
  - Row check: each of the 10 rows of 5 bits must XOR to 0.
  - Column check: for c=0..3, the XOR of data column c over the 10 rows XOR column-parity bit c must be 0.
  - Stop bit must be 0.
  - All pass: id_out loads the 40 data bits (row-major) and id_valid_out pulses.
  - Any fail: parity_err_out pulses and id_out holds.
  - Always return to HUNT with ones_cnt=0.
- Latency: if the last bit's bit_stb is in cycle S, CHECK is S+1 and the pulses are visible in S+2.
- Throughput: strobes are at least 2 cycles apart, so no bit_stb can coincide with CHECK. The bench asserts this.
- Output hold: id_out holds between successes. id_valid_out and parity_err_out are never both high.
- Trigger edges: a trigger held high produces no further strobes. Only rising edges count.

Decomposition:
- Package em4100_pkg:
  - state enum {HUNT, DATA, CHECK}
  - ID_W=40, ROWS=10, ROW_W=5, COLS=4, FRAME_BITS=55
  - function row_col_ok(frame), returns the parity/stop pass flag
- Sub-module manchester_pairer: contains edge detect, symbol pairing and slip. Outputs bit_stb, bit_val and violation_stb.

Test Plan:
- Reset → 0s: hold rst_in=0 while toggling triggers → all outputs 0; release → locked_out=0 until 9 header ones decoded.
- Good frame: ID 40'h12_3456_789A with correct row/column parity, Manchester, trigger every 4 clocks → one id_valid_out pulse 2 cycles after the final bit_stb; id_out=40'h123456789A; parity_err_out stays 0.
- Row error: same frame with row 3 parity bit inverted → parity_err_out single pulse; id_out unchanged from the previous good value; then back in HUNT.
- Phase slip: prefix a stray single symbol before the header → the first pairing violates, the decoder slips and still outputs 40'h123456789A.
- Mid-frame reset: assert rst_in=0 at data bit 20 → no pulses; id_out=0; the next full frame decodes correctly.
- NRZ mode: MANCHESTER=0, stop bit forced to 1 → parity_err_out pulse; back-to-back good frames → two id_valid_out pulses, one per frame.

Source files
------------

// File: rtl/em4100_pkg.sv
// Shared types, sizes and frame checking for the EM4100 decoder.
// A received frame is held with its first bit in frame[FRAME_BITS-1].
// The layout is 10 rows of {4 data bits, even parity}, then 4 column
// parity bits, then the stop bit in frame[0].
package em4100_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int ID_W       = 40;
  localparam int ROWS       = 10;
  localparam int ROW_W      = 5;
  localparam int COLS       = 4;
  localparam int FRAME_BITS = 55;

  // Returns 1 when every row has even parity, every column parity bit
  // matches, and the stop bit is 0.
  function automatic logic row_col_ok(input logic [FRAME_BITS-1:0] frame);
    logic            ok;
    logic            p;
    logic [COLS-1:0] col;
    ok  = 1'b1;
    col = '0;
    for (int r = 0; r < ROWS; r++) begin
      p = 1'b0;
      for (int j = 0; j < ROW_W; j++) begin
        p = p ^ frame[FRAME_BITS-1-(r*ROW_W+j)];
      end
      if (p) ok = 1'b0;
      for (int c = 0; c < COLS; c++) begin
        col[c] = col[c] ^ frame[FRAME_BITS-1-(r*ROW_W+c)];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      if (col[c] ^ frame[FRAME_BITS-1-(ROWS*ROW_W+c)]) ok = 1'b0;
    end
    if (frame[0]) ok = 1'b0;
    return ok;
  endfunction

  // Strips the parity bits; data is kept row-major, first bit at the MSB.
  function automatic logic [ID_W-1:0] extract_id(input logic [FRAME_BITS-1:0] frame);
    logic [ID_W-1:0] id;
    id = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        id[ID_W-1-(r*COLS+c)] = frame[FRAME_BITS-1-(r*ROW_W+c)];
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/em4100_decoder_pairer.sv
// Symbol strobe generation and Manchester pairing.
// Ports:
//   clk_in, rst_in         clock, async active-low reset
//   bit_in                 sliced level, sampled only on the symbol strobe
//   period_trigger_in      period trigger; each rising edge yields one symbol
//   bit_stb_out            one-cycle data-bit event
//   bit_val_out            decoded data bit, valid with bit_stb_out
//   violation_stb_out      one-cycle pulse on a 0,0 or 1,1 symbol pair
module manchester_pairer #(
  parameter int MANCHESTER = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic bit_in,
  input  logic period_trigger_in,
  output logic bit_stb_out,
  output logic bit_val_out,
  output logic violation_stb_out
);

  logic r_trig_prev;
  logic r_sym_stb;
  logic r_have_first;
  logic r_first;
  logic w_edge;
  logic w_pair_ok;

  assign w_edge    = period_trigger_in & ~r_trig_prev;
  assign w_pair_ok = r_first ^ bit_in;

  // The strobe is delayed one cycle after the trigger edge so that it lines
  // up with the slicer's registered level update.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_trig_prev  <= 1'b0;
      r_sym_stb    <= 1'b0;
      r_have_first <= 1'b0;
      r_first      <= 1'b0;
    end else begin
      r_trig_prev <= period_trigger_in;
      r_sym_stb   <= w_edge;
      if (r_sym_stb) begin
        if (!r_have_first) begin
          r_have_first <= 1'b1;
          r_first      <= bit_in;
        end else if (w_pair_ok) begin
          r_have_first <= 1'b0;
        end else begin
          // Violation: the second symbol becomes the new first half (slip).
          r_first <= bit_in;
        end
      end
    end
  end

  always_comb begin
    bit_stb_out       = 1'b0;
    bit_val_out       = 1'b0;
    violation_stb_out = 1'b0;
    if (MANCHESTER != 0) begin
      bit_stb_out       = r_sym_stb & r_have_first & w_pair_ok;
      bit_val_out       = r_first;   // 1,0 -> 1 and 0,1 -> 0
      violation_stb_out = r_sym_stb & r_have_first & ~w_pair_ok;
    end else begin
      bit_stb_out = r_sym_stb;
      bit_val_out = bit_in;
    end
  end

endmodule

// File: rtl/em4100_decoder.sv
// EM4100 frame decoder: header lock, 55-bit frame capture, parity check.
// Ports:
//   clk_in, rst_in      clock, async active-low reset
//   bit_in              sliced level from the envelope slicer
//   period_trigger_in   carrier-derived period trigger
//   id_out              last good 40-bit ID, first data bit at id_out[39]
//   id_valid_out        one-cycle pulse when id_out is updated
//   parity_err_out      one-cycle pulse on a framed frame that failed checks
//   locked_out          high in DATA or CHECK
//   dbg_state_out       current FSM state
// Valid/ready: there is no backpressure; id_valid_out and parity_err_out are
// single-cycle, mutually exclusive events and the consumer must capture them.
module em4100_decoder
  import em4100_pkg::*;
#(
  parameter int MANCHESTER = 1,
  parameter int HEADER_LEN = 9
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            bit_in,
  input  logic            period_trigger_in,
  output logic [ID_W-1:0] id_out,
  output logic            id_valid_out,
  output logic            parity_err_out,
  output logic            locked_out,
  output state_t          dbg_state_out
);

  logic w_bit_stb;
  logic w_bit_val;
  logic w_violation;

  manchester_pairer #(.MANCHESTER(MANCHESTER)) u_pairer (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .bit_in            (bit_in),
    .period_trigger_in (period_trigger_in),
    .bit_stb_out       (w_bit_stb),
    .bit_val_out       (w_bit_val),
    .violation_stb_out (w_violation)
  );

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_ones_cnt, w_ones_nxt, w_ones_inc;
  logic [5:0]            r_bit_idx, w_idx_nxt;
  logic [FRAME_BITS-1:0] r_shreg, w_shreg_nxt;
  logic [ID_W-1:0]       r_id, w_id_nxt;
  logic                  r_id_valid, w_valid_nxt;
  logic                  r_parity_err, w_err_nxt;

  // Saturating increment of the header run length.
  assign w_ones_inc = (r_ones_cnt == 4'd15) ? 4'd15 : r_ones_cnt + 4'd1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= HUNT;
      r_ones_cnt   <= '0;
      r_bit_idx    <= '0;
      r_shreg      <= '0;
      r_id         <= '0;
      r_id_valid   <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ones_cnt   <= w_ones_nxt;
      r_bit_idx    <= w_idx_nxt;
      r_shreg      <= w_shreg_nxt;
      r_id         <= w_id_nxt;
      r_id_valid   <= w_valid_nxt;
      r_parity_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ones_nxt  = r_ones_cnt;
    w_idx_nxt   = r_bit_idx;
    w_shreg_nxt = r_shreg;
    w_id_nxt    = r_id;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_violation) begin
          w_ones_nxt = '0;
        end else if (w_bit_stb) begin
          if (!w_bit_val) begin
            w_ones_nxt = '0;
          end else if (w_ones_inc >= 4'(HEADER_LEN)) begin
            w_state_nxt = DATA;
            w_ones_nxt  = '0;
            w_idx_nxt   = '0;
            w_shreg_nxt = '0;
          end else begin
            w_ones_nxt = w_ones_inc;
          end
        end
      end
      DATA: begin
        if (w_violation) begin
          // Partial frame is dropped without any pulse.
          w_state_nxt = HUNT;
          w_ones_nxt  = '0;
        end else if (w_bit_stb) begin
          w_shreg_nxt = {r_shreg[FRAME_BITS-2:0], w_bit_val};
          w_idx_nxt   = r_bit_idx + 6'd1;
          if (r_bit_idx == 6'(FRAME_BITS - 1)) w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (row_col_ok(r_shreg)) begin
          w_id_nxt    = extract_id(r_shreg);
          w_valid_nxt = 1'b1;
        end else begin
          w_err_nxt = 1'b1;
        end
        w_state_nxt = HUNT;
        w_ones_nxt  = '0;
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  assign id_out         = r_id;
  assign id_valid_out   = r_id_valid;
  assign parity_err_out = r_parity_err;
  assign locked_out     = (r_state == DATA) || (r_state == CHECK);
  assign dbg_state_out  = r_state;

endmodule

// File: tb/tb_em4100_decoder.sv
`timescale 1ns/1ps
module tb_em4100_decoder;
  import em4100_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic bit_m = 1'b0, trig_m = 1'b0;
  logic bit_n = 1'b0, trig_n = 1'b0;

  logic [39:0] id_m, id_n;
  logic        v_m, e_m, l_m, v_n, e_n, l_n;
  state_t      st_m, st_n;

  em4100_decoder #(.MANCHESTER(1), .HEADER_LEN(9)) dut (
    .clk_in(clk), .rst_in(rst_n), .bit_in(bit_m), .period_trigger_in(trig_m),
    .id_out(id_m), .id_valid_out(v_m), .parity_err_out(e_m),
    .locked_out(l_m), .dbg_state_out(st_m)
  );

  em4100_decoder #(.MANCHESTER(0), .HEADER_LEN(9)) dut_nrz (
    .clk_in(clk), .rst_in(rst_n), .bit_in(bit_n), .period_trigger_in(trig_n),
    .id_out(id_n), .id_valid_out(v_n), .parity_err_out(e_n),
    .locked_out(l_n), .dbg_state_out(st_n)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt_m = 0, ecnt_m = 0, vcnt_n = 0, ecnt_n = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- pulse monitor ----------------
  always @(negedge clk) begin
    if (v_m) vcnt_m++;
    if (e_m) ecnt_m++;
    if (v_n) vcnt_n++;
    if (e_n) ecnt_n++;
    if (v_m || e_m) begin
      n_checks++;
      if (v_m && e_m) begin
        n_fail++;
        $display("FAIL excl_m: valid=%b err=%b both high", v_m, e_m);
      end
    end
    if (dut.w_bit_stb) begin
      n_checks++;
      if (st_m == CHECK) begin
        n_fail++;
        $display("FAIL stb_in_check: bit_stb=1 state=%0d", st_m);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic sym_m(input logic b);
    @(negedge clk); bit_m = b; trig_m = 1'b1;
    @(negedge clk); @(negedge clk); trig_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic sym_n(input logic b);
    @(negedge clk); bit_n = b; trig_n = 1'b1;
    @(negedge clk); @(negedge clk); trig_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic nrz, input logic d);
    if (nrz) sym_n(d);
    else begin sym_m(d); sym_m(~d); end
  endtask

  function automatic logic [54:0] build_frame(input logic [39:0] id, input int flip_k, input logic stop);
    logic [54:0] f;
    logic [3:0]  col;
    logic        rp, d;
    f = '0; col = '0;
    for (int r = 0; r < 10; r++) begin
      rp = 1'b0;
      for (int j = 0; j < 4; j++) begin
        d = id[39-(r*4+j)];
        f[54-(r*5+j)] = d;
        rp = rp ^ d;
        col[j] = col[j] ^ d;
      end
      f[54-(r*5+4)] = rp;
    end
    for (int c = 0; c < 4; c++) f[54-(50+c)] = col[c];
    f[0] = stop;
    if (flip_k >= 0) f[54-flip_k] = ~f[54-flip_k];
    return f;
  endfunction

  // Header plus data bits [0, nbits) of the frame.
  task automatic send_frame(input logic nrz, input logic [54:0] f, input int nbits);
    for (int i = 0; i < 9; i++) send_bit(nrz, 1'b1);
    for (int i = 0; i < nbits; i++) send_bit(nrz, f[54-i]);
  endtask

  task automatic idle(input logic nrz, input int n);
    for (int i = 0; i < n; i++) send_bit(nrz, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [39:0] id;
    int          flip_k;
    logic        stop;
    logic        stray;
    int          exp_v;
    int          exp_e;
    logic [39:0] exp_id;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, e0;
    logic [54:0] f;

    vecs[0] = '{40'h123456789A, -1, 1'b0, 1'b0, 1, 0, 40'h123456789A};
    vecs[1] = '{40'h123456789A, 19, 1'b0, 1'b0, 0, 1, 40'h123456789A}; // row 3 parity
    vecs[2] = '{40'h123456789A, -1, 1'b0, 1'b1, 1, 0, 40'h123456789A}; // stray symbol
    vecs[3] = '{40'h0F1E2D3C4B, -1, 1'b0, 1'b0, 1, 0, 40'h0F1E2D3C4B};
    vecs[4] = '{40'h123456789A, 52, 1'b0, 1'b0, 0, 1, 40'h0F1E2D3C4B}; // column 2 parity
    vecs[5] = '{40'h123456789A, -1, 1'b1, 1'b0, 0, 1, 40'h0F1E2D3C4B}; // stop bit 1

    // Reset held while triggers toggle.
    rst_n = 1'b0;
    sym_m(1'b1); sym_m(1'b1); sym_m(1'b0);
    check("rst_id",     id_m, 40'h0);
    check("rst_valid",  40'(v_m), 40'h0);
    check("rst_err",    40'(e_m), 40'h0);
    check("rst_locked", 40'(l_m), 40'h0);
    check("rst_id_nrz", id_n, 40'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1);
    check("lock_after8", 40'(l_m), 40'h0);
    send_bit(1'b0, 1'b1);
    check("lock_after9", 40'(l_m), 40'h1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Table-driven frames on the Manchester decoder.
    for (int k = 0; k < 6; k++) begin
      v0 = vcnt_m; e0 = ecnt_m;
      f = build_frame(vecs[k].id, vecs[k].flip_k, vecs[k].stop);
      idle(1'b0, 2);
      if (vecs[k].stray) sym_m(1'b1);
      send_frame(1'b0, f, 55);
      idle(1'b0, 2);
      check($sformatf("v%0d_valid_cnt", k), 40'(vcnt_m - v0), 40'(vecs[k].exp_v));
      check($sformatf("v%0d_err_cnt", k),   40'(ecnt_m - e0), 40'(vecs[k].exp_e));
      check($sformatf("v%0d_id", k),        id_m, vecs[k].exp_id);
      check($sformatf("v%0d_locked", k),    40'(l_m), 40'h0);
      check($sformatf("v%0d_state", k),     40'(st_m), 40'(HUNT));
    end

    // Latency: pulse visible two cycles after the last bit_stb.
    f = build_frame(40'h123456789A, -1, 1'b0);
    idle(1'b0, 2);
    send_frame(1'b0, f, 54);
    sym_m(1'b0);                       // first half of stop bit 0
    @(negedge clk); bit_m = 1'b1; trig_m = 1'b1;
    @(negedge clk); check("lat_n1", 40'(v_m), 40'h0);
    @(negedge clk); check("lat_n2", 40'(v_m), 40'h0); trig_m = 1'b0;
    @(negedge clk); check("lat_n3", 40'(v_m), 40'h1);
    check("lat_err", 40'(e_m), 40'h0);
    check("lat_id", id_m, 40'h123456789A);
    @(negedge clk); check("lat_n4", 40'(v_m), 40'h0);
    idle(1'b0, 2);

    // Mid-frame reset at data bit 20.
    v0 = vcnt_m; e0 = ecnt_m;
    f = build_frame(40'h0F1E2D3C4B, -1, 1'b0);
    send_frame(1'b0, f, 20);
    check("mid_locked_before", 40'(l_m), 40'h1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("mid_id_zero", id_m, 40'h0);
    check("mid_locked", 40'(l_m), 40'h0);
    rst_n = 1'b1;
    idle(1'b0, 4);
    check("mid_no_pulse", 40'((vcnt_m - v0) + (ecnt_m - e0)), 40'h0);
    f = build_frame(40'h123456789A, -1, 1'b0);
    send_frame(1'b0, f, 55);
    idle(1'b0, 2);
    check("mid_next_valid", 40'(vcnt_m - v0), 40'h1);
    check("mid_next_id", id_m, 40'h123456789A);

    // NRZ decoder: bad stop bit, then two back-to-back good frames.
    v0 = vcnt_n; e0 = ecnt_n;
    idle(1'b1, 4);
    f = build_frame(40'h123456789A, -1, 1'b1);
    send_frame(1'b1, f, 55);
    idle(1'b1, 4);
    check("nrz_stop_err", 40'(ecnt_n - e0), 40'h1);
    check("nrz_stop_valid", 40'(vcnt_n - v0), 40'h0);
    check("nrz_stop_id", id_n, 40'h0);
    v0 = vcnt_n; e0 = ecnt_n;
    f = build_frame(40'h123456789A, -1, 1'b0);
    send_frame(1'b1, f, 55);
    check("nrz_b2b_id1", id_n, 40'h123456789A);
    f = build_frame(40'h0F1E2D3C4B, -1, 1'b0);
    send_frame(1'b1, f, 55);
    idle(1'b1, 4);
    check("nrz_b2b_valid", 40'(vcnt_n - v0), 40'h2);
    check("nrz_b2b_err", 40'(ecnt_n - e0), 40'h0);
    check("nrz_b2b_id2", id_n, 40'h0F1E2D3C4B);
    check("nrz_locked", 40'(l_n), 40'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
